raxm_mac_accum: RTL

RAXM_MAC_ACCUM -- requirements
Module: raxm_mac_accum

---
 rtl/raxm_mac_accum.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/raxm_mac_accum.sv
// Wishbone-controlled accumulator for an approximate-multiplier product stream.
// Sums COUNT unsigned products into an ACC_W-bit register, with sticky overflow and a done interrupt.
module raxm_mac_accum #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter int          ACC_W     = 48
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        prod_valid_i,
  input  logic [31:0] prod_data_i,
  output logic        prod_ready_o,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_COUNT  = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_ACC_LO = 8'h0C;
  localparam logic [7:0] OFF_ACC_HI = 8'h10;
  localparam logic [7:0] OFF_REMAIN = 8'h14;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [31:0]       r_shadow;
  logic [15:0]       r_count;
  logic [15:0]       r_remain;
  logic              r_irq_en;
  logic              r_done;
  logic              r_ovf;
  logic              r_zero_pend;
  logic              r_ack;
  logic [31:0]       r_dat;

  logic              w_access;
  logic              w_wr;
  logic              w_rd;
  logic [7:0]        w_off;
  logic              w_ctrl_wr;
  logic              w_clear;
  logic              w_start;
  logic              w_accept;
  logic              w_last;
  logic              w_w1c;
  logic              w_busy;
  logic [ACC_W:0]    w_sum;
  logic [63:0]       w_acc_ext;
  logic [31:0]       w_rd_data;

  assign w_access  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
  assign w_wr      = w_access & wbs_we_i;
  assign w_rd      = w_access & ~wbs_we_i;
  assign w_off     = wbs_adr_i[7:0];
  assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
  // Clear dominates start within the same CTRL write.
  assign w_clear   = w_ctrl_wr & wbs_dat_i[1];
  assign w_start   = w_ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1] & (r_state != ST_RUN);
  assign w_accept  = prod_valid_i & prod_ready_o;
  assign w_last    = w_accept & (r_remain == 16'd1);
  assign w_w1c     = w_wr & (w_off == OFF_STATUS) & wbs_dat_i[1];
  assign w_busy    = (r_state == ST_RUN);
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W-31){1'b0}}, prod_data_i};
  assign w_acc_ext = 64'(r_acc);

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_done & r_irq_en;

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_clear) begin
          w_state_nxt = ST_IDLE;
        end else if (w_start) begin
          w_state_nxt = (r_count != 16'd0) ? ST_RUN : ST_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        if (w_clear) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: products are only taken while running
  always_comb begin
    prod_ready_o = 1'b0;
    case (r_state)
      ST_RUN:  prod_ready_o = 1'b1;
      ST_IDLE: prod_ready_o = 1'b0;
      ST_DONE: prod_ready_o = 1'b0;
      default: prod_ready_o = 1'b0;
    endcase
  end

  // Accumulator datapath, remaining count and sticky flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_remain    <= 16'd0;
      r_zero_pend <= 1'b0;
    end else if (w_clear) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_remain    <= 16'd0;
      r_zero_pend <= 1'b0;
    end else if (w_start) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_remain    <= r_count;
      r_zero_pend <= (r_count == 16'd0);
    end else begin
      if (w_accept) begin
        r_acc    <= w_sum[ACC_W-1:0];
        r_ovf    <= r_ovf | w_sum[ACC_W];
        r_remain <= r_remain - 16'd1;
      end
      // A completion on this edge outranks a W1C of done.
      if (w_last || r_zero_pend) begin
        r_done <= 1'b1;
      end else if (w_w1c) begin
        r_done <= 1'b0;
      end
      r_zero_pend <= 1'b0;
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_count  <= 16'd0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_COUNT)) begin
        r_count <= wbs_dat_i[15:0];
      end
      if (w_ctrl_wr) begin
        r_irq_en <= wbs_dat_i[2];
      end
    end
  end

  // High-word shadow so an ACC_LO then ACC_HI read pair is coherent
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_shadow <= 32'd0;
    end else if (w_rd && (w_off == OFF_ACC_LO)) begin
      r_shadow <= w_acc_ext[63:32];
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Read data selection
  always_comb begin
    w_rd_data = 32'd0;
    case (w_off)
      OFF_CTRL:   w_rd_data = {29'd0, r_irq_en, 2'b00};
      OFF_COUNT:  w_rd_data = {16'd0, r_count};
      OFF_STATUS: w_rd_data = {29'd0, r_ovf, r_done, w_busy};
      OFF_ACC_LO: w_rd_data = w_acc_ext[31:0];
      OFF_ACC_HI: w_rd_data = r_shadow;
      OFF_REMAIN: w_rd_data = {16'd0, r_remain};
      default:    w_rd_data = 32'd0;
    endcase
  end

  // Bus response: single-cycle ack, data zero outside ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_rd ? w_rd_data : 32'd0;
    end
  end

endmodule
